// File: rtl/shs_pkg.sv
// Shared types and defaults for the HVAC sequencer: state encoding, counter width,
// default thresholds and timing constants.
package shs_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FAN     = 3'd1,
        ST_PRERUN  = 3'd2,
        ST_COOL    = 3'd3,
        ST_POSTRUN = 3'd4,
        ST_LOCKOUT = 3'd5,
        ST_GAS     = 3'd6
    } state_t;

    localparam int DEF_FAN_ON_TEMP = 25;
    localparam int DEF_AC_ON_TEMP  = 28;
    localparam int DEF_HYST        = 2;
    localparam int DEF_PRERUN_CYC  = 16;
    localparam int DEF_POSTRUN_CYC = 32;
    localparam int DEF_LOCKOUT_CYC = 64;

    // Timed compressor-protection states report busy.
    function automatic logic is_busy(input state_t s);
        return (s == ST_PRERUN) || (s == ST_POSTRUN) || (s == ST_LOCKOUT);
    endfunction

endpackage

// File: rtl/shs_down_counter.sv
// Loadable 16-bit down counter that saturates at zero; zero flag is combinational
// from the count register.
module shs_down_counter
    import shs_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  cnt_t load_value,
    output logic zero
);

    cnt_t count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - cnt_t'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hvac_sequencer.sv
// HVAC fan/compressor sequencer with pre-run, post-run and compressor lockout timing.
// Optional gas override is compiled in with `define GAS_OVERRIDE_EN.
module hvac_sequencer
    import shs_pkg::*;
#(
    parameter int FAN_ON_TEMP = DEF_FAN_ON_TEMP,
    parameter int AC_ON_TEMP  = DEF_AC_ON_TEMP,
    parameter int HYST        = DEF_HYST,
    parameter int PRERUN_CYC  = DEF_PRERUN_CYC,
    parameter int POSTRUN_CYC = DEF_POSTRUN_CYC,
    parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] temperature,
    input  logic       enable,
    input  logic       gas_sensor,
    output logic       fan,
    output logic       ac,
    output logic [2:0] state,
    output logic       busy
);

    localparam int   FAN_OFF_TEMP = FAN_ON_TEMP - HYST;
    localparam int   AC_OFF_TEMP  = AC_ON_TEMP - HYST;
    localparam cnt_t PRERUN_LOAD  = cnt_t'(PRERUN_CYC - 1);
    localparam cnt_t POSTRUN_LOAD = cnt_t'(POSTRUN_CYC - 1);
    localparam cnt_t LOCKOUT_LOAD = cnt_t'(LOCKOUT_CYC - 1);

    state_t state_q;
    state_t state_nx;
    logic   fan_nx;
    logic   ac_nx;
    logic   busy_nx;
    logic   cnt_load;
    cnt_t   cnt_value;
    logic   cnt_zero;
    logic   gas;
    int     temp_i;

    assign temp_i = int'(temperature);

`ifdef GAS_OVERRIDE_EN
    assign gas = gas_sensor;
`else
    logic unused_gas_sensor;
    assign unused_gas_sensor = gas_sensor;
    assign gas = 1'b0;
`endif

    shs_down_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .zero       (cnt_zero)
    );

    // Aborting a timed state reloads zero so the counter rests at 0 outside them.
    always_comb begin
        state_nx  = state_q;
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (state_q)
            ST_IDLE: begin
                if (gas) begin
                    state_nx = ST_GAS;
                end else if (enable && temp_i > FAN_ON_TEMP) begin
                    state_nx = ST_FAN;
                end
            end
            ST_FAN: begin
                if (gas) begin
                    state_nx = ST_GAS;
                end else if (!enable || temp_i <= FAN_OFF_TEMP) begin
                    state_nx = ST_IDLE;
                end else if (temp_i > AC_ON_TEMP) begin
                    state_nx  = ST_PRERUN;
                    cnt_load  = 1'b1;
                    cnt_value = PRERUN_LOAD;
                end
            end
            ST_PRERUN: begin
                if (gas) begin
                    state_nx = ST_GAS;
                    cnt_load = 1'b1;
                end else if (!enable) begin
                    state_nx = ST_IDLE;
                    cnt_load = 1'b1;
                end else if (temp_i <= AC_OFF_TEMP) begin
                    state_nx = ST_FAN;
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_nx = ST_COOL;
                end
            end
            ST_COOL: begin
                if (gas || !enable || temp_i <= AC_OFF_TEMP) begin
                    state_nx  = ST_POSTRUN;
                    cnt_load  = 1'b1;
                    cnt_value = POSTRUN_LOAD;
                end
            end
            ST_POSTRUN: begin
                if (cnt_zero) begin
                    state_nx  = ST_LOCKOUT;
                    cnt_load  = 1'b1;
                    cnt_value = LOCKOUT_LOAD;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_zero) begin
                    state_nx = (enable && temp_i > FAN_ON_TEMP) ? ST_FAN : ST_IDLE;
                end
            end
            ST_GAS: begin
                if (!gas) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_load = 1'b1;
            end
        endcase
    end

    always_comb begin
        fan_nx = 1'b0;
        case (state_nx)
            ST_FAN, ST_PRERUN, ST_COOL, ST_POSTRUN, ST_GAS: fan_nx = 1'b1;
            ST_LOCKOUT: fan_nx = (temp_i > FAN_ON_TEMP);
            default: fan_nx = 1'b0;
        endcase
        if (gas && (state_nx == ST_POSTRUN || state_nx == ST_LOCKOUT)) begin
            fan_nx = 1'b1;
        end
        ac_nx   = (state_nx == ST_COOL);
        busy_nx = is_busy(state_nx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fan     <= 1'b0;
            ac      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_nx;
            fan     <= fan_nx;
            ac      <= ac_nx;
            busy    <= busy_nx;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed self-checking bench for hvac_sequencer with default parameters;
// gas-override expectations follow `define GAS_OVERRIDE_EN.
module tb_hvac_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] temperature;
    logic       enable;
    logic       gas_sensor;
    logic       fan;
    logic       ac;
    logic [2:0] state;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    hvac_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .temperature (temperature),
        .enable      (enable),
        .gas_sensor  (gas_sensor),
        .fan         (fan),
        .ac          (ac),
        .state       (state),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outputs(input string tag, input int s, input int f, input int a, input int b);
        check_eq({tag, ".state"}, 32'(state), 32'(s));
        check_eq({tag, ".fan"},   32'(fan),   32'(f));
        check_eq({tag, ".ac"},    32'(ac),    32'(a));
        check_eq({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    // Drive FAN -> PRERUN -> COOL, checking the 16-cycle pre-run on the way.
    task automatic run_to_cool(input string tag);
        temperature = 8'd30;
        step();
        expect_outputs({tag, "_pre0"}, 2, 1, 0, 1);
        for (int i = 1; i < 16; i++) begin
            step();
            check_eq({tag, "_pre_state"}, 32'(state), 32'd2);
            check_eq({tag, "_pre_ac"},    32'(ac),    32'd0);
        end
        step();
        expect_outputs({tag, "_cool"}, 3, 1, 1, 0);
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        temperature = 8'd26;
        gas_sensor  = 1'b0;
        #1;
        expect_outputs("reset", 0, 0, 0, 0);
        step();
        expect_outputs("reset_held", 0, 0, 0, 0);

        reset = 1'b0;
        step();
        expect_outputs("first_edge", 1, 1, 0, 0);

        // Fan hysteresis around 25/23.
        temperature = 8'd23; step(); expect_outputs("fan_off23", 0, 0, 0, 0);
        temperature = 8'd25; step(); expect_outputs("idle25",    0, 0, 0, 0);
        temperature = 8'd26; step(); expect_outputs("fan_on26",  1, 1, 0, 0);
        temperature = 8'd24; step(); expect_outputs("fan_hold24", 1, 1, 0, 0);
        temperature = 8'd23; step(); expect_outputs("fan_off",   0, 0, 0, 0);
        temperature = 8'd26; step(); expect_outputs("fan_again", 1, 1, 0, 0);

        run_to_cool("c1");
        step();
        expect_outputs("cool_hold", 3, 1, 1, 0);

        // Cool off at 26, then hot again for the whole post-run and lockout.
        temperature = 8'd26;
        step();
        expect_outputs("post0", 4, 1, 0, 1);
        temperature = 8'd30;
        for (int i = 0; i < 31; i++) begin
            step();
            check_eq("post_state", 32'(state), 32'd4);
            check_eq("post_fan",   32'(fan),   32'd1);
            check_eq("post_ac",    32'(ac),    32'd0);
        end
        step();
        expect_outputs("lock0", 5, 1, 0, 1);
        for (int i = 0; i < 63; i++) begin
            step();
            check_eq("lock_state", 32'(state), 32'd5);
            check_eq("lock_ac",    32'(ac),    32'd0);
            check_eq("lock_fan",   32'(fan),   (i == 30) ? 32'd0 : 32'd1);
            temperature = (i == 29) ? 8'd20 : 8'd30;
        end
        step();
        expect_outputs("lock_exit_fan", 1, 1, 0, 0);
        step();
        expect_outputs("repre0", 2, 1, 0, 1);

        // Abort in PRERUN cycle 5.
        for (int i = 1; i < 5; i++) begin
            step();
            check_eq("abort_pre_state", 32'(state), 32'd2);
        end
        temperature = 8'd26;
        step();
        expect_outputs("abort_fan", 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("abort_state", 32'(state), 32'd1);
            check_eq("abort_ac",    32'(ac),    32'd0);
        end

        // Asynchronous reset in the middle of COOL.
        run_to_cool("c2");
        #2;
        reset = 1'b1;
        #1;
        expect_outputs("async_reset", 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        step();
        expect_outputs("after_reset", 1, 1, 0, 0);

        run_to_cool("c3");
        gas_sensor = 1'b1;
        step();
`ifdef GAS_OVERRIDE_EN
        expect_outputs("gas_post0", 4, 1, 0, 1);
        temperature = 8'd20;
        for (int i = 0; i < 31; i++) begin
            step();
            check_eq("gas_post_fan", 32'(fan), 32'd1);
        end
        step();
        expect_outputs("gas_lock0", 5, 1, 0, 1);
        for (int i = 0; i < 63; i++) begin
            step();
            check_eq("gas_lock_state", 32'(state), 32'd5);
            check_eq("gas_lock_fan",   32'(fan),   32'd1);
        end
        step();
        expect_outputs("gas_lock_exit", 0, 0, 0, 0);
        step();
        expect_outputs("gas_state", 6, 1, 0, 0);
        gas_sensor = 1'b0;
        step();
        expect_outputs("gas_clear", 0, 0, 0, 0);
`else
        expect_outputs("nogas_cool", 3, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("nogas_ac",    32'(ac),    32'd1);
            check_eq("nogas_state", 32'(state), 32'd3);
        end
        gas_sensor = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
